// File: rtl/getir_paket.sv
// Shared types for the instruction fetch stage: FSM states, fetch buffer entry
// and PC alignment helper.
package getir_paket;

  localparam int unsigned PS_W       = 32;
  localparam int unsigned KOMUT_BOYU = 4;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    BEKLE = 2'd2,
    IPTAL = 2'd3
  } durum_t;

  typedef struct packed {
    logic [PS_W-1:0] ps;
    logic [31:0]     buyruk;
    logic            dallan;
  } fifo_girdi_t;

  // Every PC loaded from outside is forced onto a word boundary.
  function automatic logic [PS_W-1:0] hizala(input logic [PS_W-1:0] adres);
    return {adres[PS_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/getir_birimi_if.sv
// Memory, predictor, execute-redirect and decode signals of the fetch stage.
interface getir_birimi_if;

  logic        bellek_istek_gecerli;
  logic [31:0] bellek_istek_adres;
  logic        bellek_istek_hazir;
  logic        bellek_yanit_gecerli;
  logic [31:0] bellek_yanit_veri;

  logic [31:0] getir_ps;
  logic [31:0] getir_buyruk;
  logic        getir_gecerli;
  logic        sonuc_dallan;
  logic [31:0] sonuc_dallan_ps;

  logic        yurut_duzelt;
  logic [31:0] yurut_duzelt_ps;

  logic        coz_gecerli;
  logic        coz_hazir;
  logic [31:0] coz_ps;
  logic [31:0] coz_buyruk;
  logic        coz_ongoru_dallan;

  modport master (
    output bellek_istek_gecerli, bellek_istek_adres,
    input  bellek_istek_hazir, bellek_yanit_gecerli, bellek_yanit_veri,
    output getir_ps, getir_buyruk, getir_gecerli,
    input  sonuc_dallan, sonuc_dallan_ps,
    input  yurut_duzelt, yurut_duzelt_ps,
    output coz_gecerli, coz_ps, coz_buyruk, coz_ongoru_dallan,
    input  coz_hazir
  );

  modport slave (
    input  bellek_istek_gecerli, bellek_istek_adres,
    output bellek_istek_hazir, bellek_yanit_gecerli, bellek_yanit_veri,
    input  getir_ps, getir_buyruk, getir_gecerli,
    output sonuc_dallan, sonuc_dallan_ps,
    output yurut_duzelt, yurut_duzelt_ps,
    input  coz_gecerli, coz_ps, coz_buyruk, coz_ongoru_dallan,
    output coz_hazir
  );

endinterface

// File: rtl/buyruk_fifo.sv
// Synchronous instruction buffer with flush; push and pop may coincide even when full.
module buyruk_fifo
  import getir_paket::*;
#(
  parameter int unsigned DERINLIK = 4,
  localparam int unsigned ADRES_W = $clog2(DERINLIK),
  localparam int unsigned SAYI_W  = ADRES_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              itme,
  input  logic              cekme,
  input  logic              bosalt,
  input  fifo_girdi_t       giris,
  output fifo_girdi_t       cikis,
  output logic [SAYI_W-1:0] sayi,
  output logic              dolu,
  output logic              bos
);

  fifo_girdi_t        bellek [DERINLIK];
  logic [ADRES_W-1:0] okuma;
  logic [ADRES_W-1:0] yazma;
  logic               itme_g;
  logic               cekme_g;

  assign bos     = (sayi == '0);
  assign dolu    = (sayi == SAYI_W'(DERINLIK));
  assign cekme_g = cekme & ~bos;
  assign itme_g  = itme & (~dolu | cekme_g);
  assign cikis   = bellek[okuma];

  // Pointers and occupancy; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      okuma <= '0;
      yazma <= '0;
      sayi  <= '0;
    end else if (bosalt) begin
      okuma <= '0;
      yazma <= '0;
      sayi  <= '0;
    end else begin
      if (itme_g)  yazma <= yazma + ADRES_W'(1);
      if (cekme_g) okuma <= okuma + ADRES_W'(1);
      sayi <= sayi + SAYI_W'(itme_g) - SAYI_W'(cekme_g);
    end
  end

  always_ff @(posedge clk) begin
    if (itme_g && !bosalt) bellek[yazma] <= giris;
  end

endmodule

// File: rtl/getir_birimi.sv
// Instruction fetch stage: PC, single-outstanding memory read FSM, predictor
// query on each returned word and a flushable buffer toward decode.
module getir_birimi
  import getir_paket::*;
#(
  parameter logic [31:0] BASLANGIC_PS  = 32'h0000_0000,
  parameter int unsigned FIFO_DERINLIK = 4
) (
  input logic           clk,
  input logic           rst,
  getir_birimi_if.master bus
);

  localparam int unsigned SAYI_W = $clog2(FIFO_DERINLIK) + 1;

  durum_t            durum;
  durum_t            durum_n;
  logic [PS_W-1:0]   ps;
  logic [PS_W-1:0]   ps_n;
  logic              itme;
  logic              bosalt;
  logic              cekme;
  logic              sorgu;
  logic              el_sikisma;
  fifo_girdi_t       giris;
  fifo_girdi_t       bas;
  logic [SAYI_W-1:0] sayi;
  logic [SAYI_W:0]   sonra_sayi;
  logic              dolu;
  logic              bos;

  assign el_sikisma = (durum == ISTEK) & bus.bellek_istek_hazir;
  assign cekme      = ~bos & bus.coz_hazir;
  // Occupancy after this cycle's push and any simultaneous pop.
  assign sonra_sayi = {1'b0, sayi} + (SAYI_W+1)'(1) - (SAYI_W+1)'(cekme);
  assign giris      = '{ps: ps, buyruk: bus.bellek_yanit_veri, dallan: bus.sonuc_dallan};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum <= BOSTA;
      ps    <= hizala(BASLANGIC_PS);
    end else begin
      durum <= durum_n;
      ps    <= ps_n;
    end
  end

  always_comb begin
    durum_n = durum;
    ps_n    = ps;
    itme    = 1'b0;
    bosalt  = 1'b0;
    sorgu   = 1'b0;
    if (bus.yurut_duzelt) begin
      bosalt = 1'b1;
      ps_n   = hizala(bus.yurut_duzelt_ps);
      unique case (durum)
        BOSTA:   durum_n = ISTEK;
        ISTEK:   durum_n = el_sikisma ? IPTAL : ISTEK;
        // A response landing now is the one being cancelled, so nothing is left to wait for.
        BEKLE,
        IPTAL:   durum_n = bus.bellek_yanit_gecerli ? ISTEK : IPTAL;
        default: durum_n = BOSTA;
      endcase
    end else begin
      unique case (durum)
        BOSTA: if (!dolu) durum_n = ISTEK;
        ISTEK: if (el_sikisma) durum_n = BEKLE;
        BEKLE: begin
          if (bus.bellek_yanit_gecerli) begin
            sorgu   = 1'b1;
            itme    = 1'b1;
            ps_n    = bus.sonuc_dallan ? hizala(bus.sonuc_dallan_ps)
                                       : ps + PS_W'(KOMUT_BOYU);
            durum_n = (sonra_sayi < (SAYI_W+1)'(FIFO_DERINLIK)) ? ISTEK : BOSTA;
          end
        end
        IPTAL: if (bus.bellek_yanit_gecerli) durum_n = ISTEK;
        default: durum_n = BOSTA;
      endcase
    end
  end

  buyruk_fifo #(
    .DERINLIK (FIFO_DERINLIK)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .itme   (itme),
    .cekme  (cekme),
    .bosalt (bosalt),
    .giris  (giris),
    .cikis  (bas),
    .sayi   (sayi),
    .dolu   (dolu),
    .bos    (bos)
  );

  assign bus.bellek_istek_gecerli = (durum == ISTEK);
  assign bus.bellek_istek_adres   = ps;
  assign bus.getir_gecerli        = sorgu;
  assign bus.getir_ps             = ps;
  assign bus.getir_buyruk         = sorgu ? bus.bellek_yanit_veri : 32'h0;
  assign bus.coz_gecerli          = ~bos;
  assign bus.coz_ps               = bos ? 32'h0 : bas.ps;
  assign bus.coz_buyruk           = bos ? 32'h0 : bas.buyruk;
  assign bus.coz_ongoru_dallan    = ~bos & bas.dallan;

endmodule

// File: tb/tb_getir_birimi.sv
// Directed bench for getir_birimi; the bench plays memory, predictor, execute and decode.
module tb_getir_birimi;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  getir_birimi_if bus ();

  getir_birimi #(
    .BASLANGIC_PS  (32'h0000_0000),
    .FIFO_DERINLIK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_assert++;
    assert (gozlenen === beklenen)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request/response pair: accept immediately, answer the next cycle.
  task automatic getir(input logic [31:0] adres, input logic [31:0] veri,
                       input logic dallan, input logic [31:0] hedef);
    kontrol("istek_gecerli", 32'(bus.bellek_istek_gecerli), 32'd1);
    kontrol("istek_adres", bus.bellek_istek_adres, adres);
    bus.bellek_istek_hazir = 1'b1;
    tick();
    bus.bellek_istek_hazir   = 1'b0;
    bus.bellek_yanit_gecerli = 1'b1;
    bus.bellek_yanit_veri    = veri;
    bus.sonuc_dallan         = dallan;
    bus.sonuc_dallan_ps      = hedef;
    #1;
    kontrol("getir_gecerli", 32'(bus.getir_gecerli), 32'd1);
    kontrol("getir_ps", bus.getir_ps, adres);
    kontrol("getir_buyruk", bus.getir_buyruk, veri);
    tick();
    bus.bellek_yanit_gecerli = 1'b0;
    bus.sonuc_dallan         = 1'b0;
    bus.sonuc_dallan_ps      = 32'h0;
  endtask

  task automatic coz_kontrol(input logic [31:0] ps, input logic [31:0] buyruk, input logic dallan);
    kontrol("coz_gecerli", 32'(bus.coz_gecerli), 32'd1);
    kontrol("coz_ps", bus.coz_ps, ps);
    kontrol("coz_buyruk", bus.coz_buyruk, buyruk);
    kontrol("coz_dallan", 32'(bus.coz_ongoru_dallan), 32'(dallan));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.bellek_istek_hazir   = 1'b0;
    bus.bellek_yanit_gecerli = 1'b0;
    bus.bellek_yanit_veri    = 32'h0;
    bus.sonuc_dallan         = 1'b0;
    bus.sonuc_dallan_ps      = 32'h0;
    bus.yurut_duzelt         = 1'b0;
    bus.yurut_duzelt_ps      = 32'h0;
    bus.coz_hazir            = 1'b1;

    // Reset values
    #2;
    kontrol("rst_istek_gecerli", 32'(bus.bellek_istek_gecerli), 32'd0);
    kontrol("rst_istek_adres", bus.bellek_istek_adres, 32'h0);
    kontrol("rst_getir_gecerli", 32'(bus.getir_gecerli), 32'd0);
    kontrol("rst_getir_ps", bus.getir_ps, 32'h0);
    kontrol("rst_coz_gecerli", 32'(bus.coz_gecerli), 32'd0);
    kontrol("rst_coz_ps", bus.coz_ps, 32'h0);

    // Release; first edge moves to ISTEK
    #10 rst = 1'b1;
    kontrol("bosta_istek_yok", 32'(bus.bellek_istek_gecerli), 32'd0);
    tick();

    // Sequential not-taken fetches, decode always ready
    getir(32'h0, 32'hA000_0000, 1'b0, 32'h0);
    coz_kontrol(32'h0, 32'hA000_0000, 1'b0);
    getir(32'h4, 32'hA000_0004, 1'b0, 32'h0);
    coz_kontrol(32'h4, 32'hA000_0004, 1'b0);
    getir(32'h8, 32'hA000_0008, 1'b0, 32'h0);
    coz_kontrol(32'h8, 32'hA000_0008, 1'b0);
    getir(32'hC, 32'hA000_000C, 1'b0, 32'h0);
    coz_kontrol(32'hC, 32'hA000_000C, 1'b0);

    // Decode stalls: buffer fills to four entries and requests stop
    getir(32'h10, 32'hB000_0010, 1'b0, 32'h0);
    bus.coz_hazir = 1'b0;
    coz_kontrol(32'h10, 32'hB000_0010, 1'b0);
    getir(32'h14, 32'hB000_0014, 1'b0, 32'h0);
    getir(32'h18, 32'hB000_0018, 1'b0, 32'h0);
    getir(32'h1C, 32'hB000_001C, 1'b0, 32'h0);
    kontrol("dolu_istek_yok0", 32'(bus.bellek_istek_gecerli), 32'd0);
    tick();
    kontrol("dolu_istek_yok1", 32'(bus.bellek_istek_gecerli), 32'd0);
    tick();
    kontrol("dolu_istek_yok2", 32'(bus.bellek_istek_gecerli), 32'd0);
    coz_kontrol(32'h10, 32'hB000_0010, 1'b0);

    // A single pop re-enables exactly one request
    bus.coz_hazir = 1'b1;
    tick();
    bus.coz_hazir = 1'b0;
    kontrol("pop_sonrasi_bosta", 32'(bus.bellek_istek_gecerli), 32'd0);
    coz_kontrol(32'h14, 32'hB000_0014, 1'b0);
    tick();
    kontrol("pop_istek", 32'(bus.bellek_istek_gecerli), 32'd1);
    kontrol("pop_istek_adres", bus.bellek_istek_adres, 32'h20);

    // Redirect while waiting in BEKLE: flush, discard the late response
    bus.bellek_istek_hazir = 1'b1;
    tick();
    bus.bellek_istek_hazir = 1'b0;
    bus.yurut_duzelt       = 1'b1;
    bus.yurut_duzelt_ps    = 32'h0000_0100;
    #1;
    kontrol("duzelt_bekle_gecerli", 32'(bus.getir_gecerli), 32'd0);
    tick();
    bus.yurut_duzelt = 1'b0;
    kontrol("duzelt_flush", 32'(bus.coz_gecerli), 32'd0);
    kontrol("iptal_istek_yok", 32'(bus.bellek_istek_gecerli), 32'd0);
    bus.bellek_yanit_gecerli = 1'b1;
    bus.bellek_yanit_veri    = 32'hDEAD_BEEF;
    #1;
    kontrol("iptal_atilan_yanit", 32'(bus.getir_gecerli), 32'd0);
    tick();
    bus.bellek_yanit_gecerli = 1'b0;
    kontrol("iptal_itme_yok", 32'(bus.coz_gecerli), 32'd0);
    kontrol("iptal_sonra_istek", 32'(bus.bellek_istek_gecerli), 32'd1);
    kontrol("iptal_sonra_adres", bus.bellek_istek_adres, 32'h100);

    // Redirect to a misaligned target on the response cycle
    bus.bellek_istek_hazir = 1'b1;
    tick();
    bus.bellek_istek_hazir   = 1'b0;
    bus.bellek_yanit_gecerli = 1'b1;
    bus.bellek_yanit_veri    = 32'h1234_5678;
    bus.sonuc_dallan         = 1'b1;
    bus.sonuc_dallan_ps      = 32'h0000_0500;
    bus.yurut_duzelt         = 1'b1;
    bus.yurut_duzelt_ps      = 32'h0000_0103;
    #1;
    kontrol("yanitla_duzelt_gecerli", 32'(bus.getir_gecerli), 32'd0);
    tick();
    bus.bellek_yanit_gecerli = 1'b0;
    bus.sonuc_dallan         = 1'b0;
    bus.yurut_duzelt         = 1'b0;
    kontrol("yanitla_duzelt_itme_yok", 32'(bus.coz_gecerli), 32'd0);
    kontrol("yanitla_duzelt_istek", 32'(bus.bellek_istek_gecerli), 32'd1);
    kontrol("yanitla_duzelt_adres", bus.bellek_istek_adres, 32'h100);

    // Redirect from ISTEK without handshake, then predictor-taken fetches
    bus.coz_hazir       = 1'b1;
    bus.yurut_duzelt    = 1'b1;
    bus.yurut_duzelt_ps = 32'h0000_0004;
    tick();
    bus.yurut_duzelt = 1'b0;
    getir(32'h4, 32'hC000_0004, 1'b1, 32'h0000_0010);
    kontrol("dallan_adres", bus.bellek_istek_adres, 32'h10);
    coz_kontrol(32'h4, 32'hC000_0004, 1'b1);
    getir(32'h10, 32'hC000_0010, 1'b1, 32'hFFFF_FFFE);
    kontrol("hedef_hizali", bus.bellek_istek_adres, 32'hFFFF_FFFC);
    coz_kontrol(32'h10, 32'hC000_0010, 1'b1);
    getir(32'hFFFF_FFFC, 32'hC000_FFFC, 1'b0, 32'h0);
    kontrol("ps_sarma", bus.bellek_istek_adres, 32'h0);
    coz_kontrol(32'hFFFF_FFFC, 32'hC000_FFFC, 1'b0);

    // Asynchronous reset in ISTEK drops the request at once
    #2 rst = 1'b0;
    #1;
    kontrol("async_istek_dus", 32'(bus.bellek_istek_gecerli), 32'd0);
    kontrol("async_coz_bos", 32'(bus.coz_gecerli), 32'd0);
    kontrol("async_adres", bus.bellek_istek_adres, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    bus.bellek_yanit_gecerli = 1'b1;
    bus.bellek_yanit_veri    = 32'h5555_AAAA;
    #1;
    kontrol("rst_sonrasi_yanit_yok", 32'(bus.getir_gecerli), 32'd0);
    tick();
    bus.bellek_yanit_gecerli = 1'b0;
    kontrol("rst_sonrasi_itme_yok", 32'(bus.coz_gecerli), 32'd0);
    kontrol("rst_sonrasi_istek", 32'(bus.bellek_istek_gecerli), 32'd1);
    kontrol("rst_sonrasi_adres", bus.bellek_istek_adres, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
